// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one block-memory port between I-cache fills and
//               D-cache refills/write-backs (D priority, bounded I starvation)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_RD   = 2'd2,
        D_WR   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [STREAK_W-1:0] r_streak;
    logic                w_grant_i;
    logic                w_grant_dr;
    logic                w_grant_dw;
    logic                w_done;
    logic                w_own_i;
    logic                w_own_dr;
    logic                w_own_d;

    assign w_own_i  = (r_state == I_BUSY);
    assign w_own_dr = (r_state == D_RD);
    assign w_own_d  = (r_state == D_RD) || (r_state == D_WR);
    assign w_done   = mem_ready && (r_state != IDLE);

    always_comb begin
        w_next     = r_state;
        w_grant_i  = 1'b0;
        w_grant_dr = 1'b0;
        w_grant_dw = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_mem_read && (r_streak == c_STREAK_MAX)) begin
                    w_next    = I_BUSY;
                    w_grant_i = 1'b1;
                end else if (d_mem_write) begin
                    w_next     = D_WR;
                    w_grant_dw = 1'b1;
                end else if (d_mem_read) begin
                    w_next     = D_RD;
                    w_grant_dr = 1'b1;
                end else if (i_mem_read) begin
                    w_next    = I_BUSY;
                    w_grant_i = 1'b1;
                end
            end
            default: begin
                if (mem_ready) begin
                    w_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_streak  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            r_state <= w_next;

            if (w_grant_i) begin
                mem_read  <= 1'b1;
                mem_addr  <= i_mem_addr;
                mem_wdata <= '0;
            end else if (w_grant_dr) begin
                mem_read  <= 1'b1;
                mem_addr  <= d_mem_addr;
                mem_wdata <= '0;
            end else if (w_grant_dw) begin
                mem_write <= 1'b1;
                mem_addr  <= d_mem_addr;
                mem_wdata <= d_mem_wdata;
            end else if (w_done) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end

            // Streak only moves in IDLE; it bounds how long a pending I fill waits.
            if (r_state == IDLE) begin
                if (w_grant_i || !i_mem_read) begin
                    r_streak <= '0;
                end else if ((w_grant_dr || w_grant_dw) && (r_streak != c_STREAK_MAX)) begin
                    r_streak <= r_streak + STREAK_W'(1);
                end
            end
        end
    end

    assign i_mem_ready = mem_ready && w_own_i;
    assign d_mem_ready = mem_ready && w_own_d;
    assign i_mem_rdata = mem_rdata & {DATA_W{w_own_i}};
    assign d_mem_rdata = mem_rdata & {DATA_W{w_own_dr}};

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [DATA_W-1:0] c_IDATA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [DATA_W-1:0] c_WDATA = 128'h11112222_33334444_55556666_77778888;
    localparam logic [DATA_W-1:0] c_DDATA = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [ADDR_W-1:0] c_IADDR = 28'h0000010;
    localparam logic [ADDR_W-1:0] c_DADDR = 28'h0ABCDE0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
        .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_mem_read = 1'b0; i_mem_addr = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
        mem_rdata = c_IDATA; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_read",   mem_read,    0);
        chk("rst_write",  mem_write,   0);
        chk("rst_addr",   mem_addr,    0);
        chk("rst_wdata",  mem_wdata,   0);
        chk("rst_irdata", i_mem_rdata, 0);
        chk("rst_drdata", d_mem_rdata, 0);
        chk("rst_streak", dut.r_streak, 0);
        rst = 1'b0;
        tick();

        // Single I read, memory answers 5 cycles after the strobe
        i_mem_read = 1'b1; i_mem_addr = c_IADDR;
        tick();
        chk("i1_read", mem_read, 1);
        chk("i1_addr", mem_addr, c_IADDR);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("i1_hold", {mem_read, mem_addr}, {1'b1, c_IADDR});
            chk("i1_noready", i_mem_ready, 0);
        end
        tick();
        mem_ready = 1'b1; mem_rdata = c_IDATA;
        #1;
        chk("i1_ready", i_mem_ready, 1);
        chk("i1_rdata", i_mem_rdata, c_IDATA);
        chk("i1_dready", d_mem_ready, 0);
        tick();
        mem_ready = 1'b0; i_mem_read = 1'b0;
        #1;
        chk("i1_clear", mem_read, 0);
        chk("i1_pulse", i_mem_ready, 0);
        tick();

        // D write and I read raised together: write wins
        i_mem_read = 1'b1; i_mem_addr = c_IADDR;
        d_mem_write = 1'b1; d_mem_addr = c_DADDR; d_mem_wdata = c_WDATA;
        tick();
        chk("dw_write", mem_write, 1);
        chk("dw_read",  mem_read,  0);
        chk("dw_addr",  mem_addr,  c_DADDR);
        chk("dw_wdata", mem_wdata, c_WDATA);
        chk("dw_streak", dut.r_streak, 1);
        tick();
        mem_ready = 1'b1; mem_rdata = c_DDATA;
        #1;
        chk("dw_dready", d_mem_ready, 1);
        chk("dw_drdata", d_mem_rdata, 0);
        chk("dw_iready", i_mem_ready, 0);
        tick();
        mem_ready = 1'b0; d_mem_write = 1'b0;
        #1;
        chk("dw_turn", {mem_read, mem_write}, 0);
        tick();
        chk("dw_igrant", {mem_read, mem_addr}, {1'b1, c_IADDR});
        chk("dw_streak0", dut.r_streak, 0);
        mem_ready = 1'b1; mem_rdata = c_IDATA;
        #1;
        chk("dw_iready2", i_mem_ready, 1);
        tick();
        mem_ready = 1'b0; i_mem_read = 1'b0;
        tick();

        // D read and write both high: write first, then read
        d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_addr = c_DADDR; d_mem_wdata = c_WDATA;
        tick();
        chk("rw_write", {mem_write, mem_read}, 2'b10);
        mem_ready = 1'b1;
        #1;
        chk("rw_wready", d_mem_ready, 1);
        tick();
        mem_ready = 1'b0; d_mem_write = 1'b0;
        tick();
        chk("rw_read", {mem_write, mem_read}, 2'b01);
        chk("rw_wdata0", mem_wdata, 0);
        mem_ready = 1'b1; mem_rdata = c_DDATA;
        #1;
        chk("rw_rready", d_mem_ready, 1);
        chk("rw_rdata",  d_mem_rdata, c_DDATA);
        chk("rw_irdata", i_mem_rdata, 0);
        tick();
        mem_ready = 1'b0; d_mem_read = 1'b0;
        tick();

        // Starvation bound: 4 D grants, then I is forced in
        i_mem_read = 1'b1; i_mem_addr = c_IADDR;
        d_mem_read = 1'b1; d_mem_addr = c_DADDR;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("st_dgrant", {mem_read, mem_addr}, {1'b1, c_DADDR});
            chk("st_streak", dut.r_streak, k + 1);
            mem_ready = 1'b1; mem_rdata = c_DDATA;
            #1;
            chk("st_dready", {d_mem_ready, i_mem_ready}, 2'b10);
            tick();
            mem_ready = 1'b0;
        end
        tick();
        chk("st_igrant", {mem_read, mem_addr}, {1'b1, c_IADDR});
        chk("st_streak0", dut.r_streak, 0);
        mem_ready = 1'b1; mem_rdata = c_IDATA;
        #1;
        chk("st_iready", {d_mem_ready, i_mem_ready}, 2'b01);
        chk("st_irdata", i_mem_rdata, c_IDATA);
        tick();
        mem_ready = 1'b0; i_mem_read = 1'b0; d_mem_read = 1'b0;
        tick();

        // Stray mem_ready while IDLE
        mem_ready = 1'b1;
        #1;
        chk("stray_ready", {i_mem_ready, d_mem_ready}, 0);
        tick();
        chk("stray_state", dut.r_state, 0);
        chk("stray_strobe", {mem_read, mem_write}, 0);
        mem_ready = 1'b0;
        tick();

        // Async reset in the middle of a D read, with I pending
        i_mem_read = 1'b1; i_mem_addr = c_IADDR;
        d_mem_read = 1'b1; d_mem_addr = c_DADDR;
        tick();
        chk("rr_dgrant", {mem_read, mem_addr}, {1'b1, c_DADDR});
        #2;
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rr_read",   mem_read,  0);
        chk("rr_addr",   mem_addr,  0);
        chk("rr_ready",  {i_mem_ready, d_mem_ready}, 0);
        chk("rr_rdata",  d_mem_rdata, 0);
        tick();
        mem_ready = 1'b0; d_mem_read = 1'b0;
        rst = 1'b0;
        tick();
        chk("rr_igrant", {mem_read, mem_addr}, {1'b1, c_IADDR});
        mem_ready = 1'b1; mem_rdata = c_IDATA;
        #1;
        chk("rr_iready", i_mem_ready, 1);
        tick();
        mem_ready = 1'b0; i_mem_read = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
